// File: rtl/sun_tracker_scanner.sv
// Scans the east/west light sensors through a 2:1 mux, captures each reading after a
// settle window and issues a one-cycle deadband-filtered rotation decision.
module sun_tracker_scanner #(
  parameter int WIDTH    = 4,
  parameter int SETTLE   = 3,
  parameter int DEADBAND = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mux_data,
  output logic             mux_sel,
  output logic [WIDTH-1:0] east_val,
  output logic [WIDTH-1:0] west_val,
  output logic [1:0]       dir,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETTLE_E, SETTLE_W, DECIDE} state_t;

  localparam logic [3:0]     LAST = 4'(SETTLE - 1);
  localparam logic [WIDTH:0] DB   = (WIDTH + 1)'(DEADBAND);

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_EAST = 2'b01;
  localparam logic [1:0] DIR_WEST = 2'b10;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] next_dir;

  // One extra bit of headroom so reading + DEADBAND cannot wrap.
  logic [WIDTH:0] east_ext, west_ext;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    east_ext = {1'b0, east_val};
    west_ext = {1'b0, west_val};
    next_dir = DIR_HOLD;
    if (east_ext > west_ext + DB)
      next_dir = DIR_EAST;
    else if (west_ext > east_ext + DB)
      next_dir = DIR_WEST;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mux_sel  <= 1'b0;
      east_val <= '0;
      west_val <= '0;
      dir      <= DIR_HOLD;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          mux_sel <= 1'b0;
          if (start) begin
            state <= SETTLE_E;
            cnt   <= 4'd0;
            busy  <= 1'b1;
          end
        end
        SETTLE_E: begin
          if (cnt == LAST) begin
            east_val <= mux_data;
            mux_sel  <= 1'b1;
            cnt      <= 4'd0;
            state    <= SETTLE_W;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SETTLE_W: begin
          if (cnt == LAST) begin
            west_val <= mux_data;
            mux_sel  <= 1'b0;
            cnt      <= 4'd0;
            state    <= DECIDE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DECIDE: begin
          dir   <= next_dir;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sun_tracker_scanner.sv
// Directed bench for sun_tracker_scanner: a table of east/west pairs with hand-computed
// decisions, plus sequences for ignored starts, back-to-back scans, reset abort and glitches.
module tb_sun_tracker_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mux_data;
  logic       mux_sel;
  logic [3:0] east_val, west_val;
  logic [1:0] dir;
  logic       valid, busy;

  logic [3:0] east_ch, west_ch;

  int passed = 0;
  int total  = 0;

  sun_tracker_scanner #(.WIDTH(4), .SETTLE(3), .DEADBAND(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mux_data (mux_data),
    .mux_sel  (mux_sel),
    .east_val (east_val),
    .west_val (west_val),
    .dir      (dir),
    .valid    (valid),
    .busy     (busy)
  );

  // Combinational sensor multiplexer.
  assign mux_data = mux_sel ? west_ch : east_ch;

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] east;
    logic [3:0] west;
    logic [1:0] exp_dir;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One full scan from start at edge 0; start_mask[k] drives start before edge k,
  // glitch inverts the east channel before edges 1 and 2.
  task automatic do_scan(input logic [3:0] e, input logic [3:0] w, input logic [1:0] exp_dir,
                         input logic [7:0] start_mask, input bit glitch);
    east_ch = e;
    west_ch = w;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_edge0", busy, 1);
    check("sel_after_edge0", mux_sel, 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start   = start_mask[k];
      east_ch = (glitch && k <= 2) ? ~e : e;
      @(posedge clk);
      #1;
      check($sformatf("sel_edge%0d", k), mux_sel, (k >= 3 && k <= 5) ? 1 : 0);
      check($sformatf("valid_edge%0d", k), valid, (k == 7) ? 1 : 0);
      check($sformatf("busy_edge%0d", k), busy, (k < 7) ? 1 : 0);
    end
    check("east_val", east_val, e);
    check("west_val", west_val, w);
    check("dir", dir, exp_dir);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("valid_drop", valid, 0);
    check("dir_hold", dir, exp_dir);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'b1010, 4'b0011, 2'b01};
    vecs[1] = '{4'b0101, 4'b0111, 2'b10};
    vecs[2] = '{4'b0110, 4'b0111, 2'b00};
    vecs[3] = '{4'b1111, 4'b1111, 2'b00};
    vecs[4] = '{4'b1111, 4'b0000, 2'b01};
    vecs[5] = '{4'b0000, 4'b1111, 2'b10};

    rst     = 1'b1;
    start   = 1'b0;
    east_ch = 4'h0;
    west_ch = 4'h0;
    #1;
    check("rst_sel", mux_sel, 0);
    check("rst_east", east_val, 0);
    check("rst_west", west_val, 0);
    check("rst_dir", dir, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_scan(vecs[i].east, vecs[i].west, vecs[i].exp_dir, 8'h00, 1'b0);

    // Extra starts at edges 2 and 5 must be ignored.
    do_scan(4'b0101, 4'b1000, 2'b10, 8'b0010_0100, 1'b0);

    // Glitch in the east settle window; only the edge-3 value counts.
    do_scan(4'b1100, 4'b0001, 2'b01, 8'h00, 1'b1);

    // start held high: valid every 8 cycles with no dead cycle.
    east_ch = 4'b0010;
    west_ch = 4'b1001;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b_valid%0d", k), valid, ((k % 8) == 7) ? 1 : 0);
      check($sformatf("b2b_busy%0d", k), busy, ((k % 8) == 7) ? 0 : 1);
    end
    check("b2b_dir", dir, 2'b10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle", busy, 0);

    // Reset mid-scan after a completed dir=01 scan.
    do_scan(4'b1010, 4'b0011, 2'b01, 8'h00, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_dir", dir, 0);
    check("abort_east", east_val, 0);
    check("abort_west", west_val, 0);
    check("abort_sel", mux_sel, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_novalid%0d", k), valid, 0);
    end
    do_scan(4'b0110, 4'b0100, 2'b01, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
